// File: rtl/rx_tx_pkg.sv
// Framing constants and state encoding shared by
// the simple transmit and receive paths.
package rx_tx_pkg;

    localparam logic [31:0] C_SFD         = 32'h5555_557F;
    localparam logic [15:0] C_PACKET_TYPE = 16'h1234;
    localparam logic [7:0]  C_SIZE_MIN    = 8'h08;
    localparam logic [7:0]  C_GAP_LEN     = 8'd12;

    typedef enum logic [2:0] {
        S_LOAD,
        S_DROP,
        S_SFD,
        S_TYPE,
        S_SIZE,
        S_PAYLOAD,
        S_FCS,
        S_GAP
    } state_t;

    function automatic logic [7:0] pad_len(input logic [7:0] n);
        return (n < C_SIZE_MIN) ? C_SIZE_MIN : n;
    endfunction

    // Index 0 selects the most significant SFD byte.
    function automatic logic [7:0] sfd_byte(input logic [1:0] i);
        logic [4:0] sh;
        sh = {~i, 3'b000};
        return C_SFD[sh +: 8];
    endfunction

    function automatic logic [7:0] type_byte(input logic i);
        return i ? C_PACKET_TYPE[7:0] : C_PACKET_TYPE[15:8];
    endfunction

endpackage

// File: rtl/simple_tx_if.sv
// Stream input, line output and statistics bundle
// of the simple transmitter.
interface simple_tx_if;

    logic [7:0]  tdata_in;
    logic        tvalid_in;
    logic        tlast_in;
    logic        tready_out;
    logic [7:0]  txd_out;
    logic        txdv_out;
    logic        txer_out;
    logic [15:0] stat_packet_sent_cnt;
    logic [15:0] stat_packet_drop_cnt;

    modport master (
        output tdata_in, tvalid_in, tlast_in,
        input  tready_out, txd_out, txdv_out, txer_out,
        input  stat_packet_sent_cnt, stat_packet_drop_cnt
    );

    modport slave (
        input  tdata_in, tvalid_in, tlast_in,
        output tready_out, txd_out, txdv_out, txer_out,
        output stat_packet_sent_cnt, stat_packet_drop_cnt
    );

endinterface

// File: rtl/tx_fsm.sv
// Frame sequencer: walks SFD/type/size/payload/FCS/gap
// and owns the registered line outputs and statistics.
module tx_fsm
    import rx_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_beat,
    input  logic        i_last,
    input  logic        i_full,
    input  logic [7:0]  i_len,
    input  logic [7:0]  i_fcs,
    input  logic [7:0]  i_rdata,
    output state_t      o_state,
    output logic [7:0]  o_idx,
    output logic [7:0]  o_txd,
    output logic        o_txdv,
    output logic [15:0] o_sent_cnt,
    output logic [15:0] o_drop_cnt
);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_txd;
    logic        r_txdv;
    logic [15:0] r_sent;
    logic [15:0] r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_cnt   <= 8'd0;
            r_txd   <= 8'h00;
            r_txdv  <= 1'b0;
            r_sent  <= 16'd0;
            r_drop  <= 16'd0;
        end else begin
            r_txd  <= 8'h00;
            r_txdv <= 1'b0;
            unique case (r_state)
                S_LOAD: begin
                    if (i_beat) begin
                        if (i_full) begin
                            if (i_last) r_drop  <= r_drop + 16'd1;
                            else        r_state <= S_DROP;
                        end else if (i_last) begin
                            r_state <= S_SFD;
                            r_cnt   <= 8'd0;
                        end
                    end
                end
                S_DROP: begin
                    if (i_beat && i_last) begin
                        r_drop  <= r_drop + 16'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_SFD: begin
                    r_txd  <= sfd_byte(r_cnt[1:0]);
                    r_txdv <= 1'b1;
                    if (r_cnt == 8'd3) begin
                        r_state <= S_TYPE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_TYPE: begin
                    r_txd  <= type_byte(r_cnt[0]);
                    r_txdv <= 1'b1;
                    if (r_cnt == 8'd1) begin
                        r_state <= S_SIZE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SIZE: begin
                    r_txd   <= i_len;
                    r_txdv  <= 1'b1;
                    r_state <= S_PAYLOAD;
                    r_cnt   <= 8'd0;
                end
                S_PAYLOAD: begin
                    r_txd  <= i_rdata;
                    r_txdv <= 1'b1;
                    if (r_cnt == i_len - 8'd1) begin
                        r_state <= S_FCS;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_FCS: begin
                    r_txd   <= i_fcs;
                    r_txdv  <= 1'b1;
                    r_sent  <= r_sent + 16'd1;
                    r_state <= S_GAP;
                    r_cnt   <= 8'd0;
                end
                S_GAP: begin
                    if (r_cnt == C_GAP_LEN - 8'd1) begin
                        r_state <= S_LOAD;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign o_state    = r_state;
    assign o_idx      = r_cnt;
    assign o_txd      = r_txd;
    assign o_txdv     = r_txdv;
    assign o_sent_cnt = r_sent;
    assign o_drop_cnt = r_drop;

endmodule

// File: rtl/simple_tx.sv
// Packet transmitter: buffers one stream packet, then
// emits it as a framed, padded, XOR-checked line burst.
module simple_tx
    import rx_tx_pkg::*;
#(
    parameter int G_MEM_SIZE = 100
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    simple_tx_if.slave  bus
);

    localparam int AW = $clog2(G_MEM_SIZE);

    logic [7:0] r_mem [0:G_MEM_SIZE-1];
    logic [7:0] r_waddr;
    logic [7:0] r_acc;
    logic [7:0] r_len;
    logic [7:0] r_fcs;

    state_t     w_state;
    logic [7:0] w_idx;
    logic [7:0] w_rdata;
    logic       w_load;
    logic       w_tready;
    logic       w_beat;
    logic       w_full;
    logic       w_wr;

    assign w_load   = (w_state == S_LOAD);
    assign w_tready = rst_n_in & (w_load | (w_state == S_DROP));
    assign w_beat   = bus.tvalid_in & w_tready;
    assign w_full   = (r_waddr == 8'(G_MEM_SIZE));
    assign w_wr     = w_beat & w_load & ~w_full;

    always_ff @(posedge clk_in) begin
        if (w_wr) r_mem[r_waddr[AW-1:0]] <= bus.tdata_in;
    end

    // Padding bytes are zero, so they leave the running XOR unchanged.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_waddr <= 8'd0;
            r_acc   <= 8'h00;
            r_len   <= 8'd0;
            r_fcs   <= 8'h00;
        end else if (w_beat && w_load) begin
            if (w_full) begin
                r_waddr <= 8'd0;
                r_acc   <= 8'h00;
            end else if (bus.tlast_in) begin
                r_len   <= r_waddr + 8'd1;
                r_fcs   <= r_acc ^ bus.tdata_in;
                r_waddr <= 8'd0;
                r_acc   <= 8'h00;
            end else begin
                r_waddr <= r_waddr + 8'd1;
                r_acc   <= r_acc ^ bus.tdata_in;
            end
        end
    end

    assign w_rdata = (w_idx < r_len) ? r_mem[w_idx[AW-1:0]] : 8'h00;

    tx_fsm u_fsm (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .i_beat     (w_beat),
        .i_last     (bus.tlast_in),
        .i_full     (w_full),
        .i_len      (pad_len(r_len)),
        .i_fcs      (r_fcs),
        .i_rdata    (w_rdata),
        .o_state    (w_state),
        .o_idx      (w_idx),
        .o_txd      (bus.txd_out),
        .o_txdv     (bus.txdv_out),
        .o_sent_cnt (bus.stat_packet_sent_cnt),
        .o_drop_cnt (bus.stat_packet_drop_cnt)
    );

    assign bus.tready_out = w_tready;
    assign bus.txer_out   = 1'b0;

endmodule

// File: tb/tb_simple_tx.sv
// Scoreboard bench for simple_tx: expected line bytes
// are queued when a packet is driven and popped by a monitor.
module tb_simple_tx;

    logic clk;
    logic rst_n;

    simple_tx_if bus();

    simple_tx #(.G_MEM_SIZE(100)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         runs[$];
    int         run_len  = 0;
    logic [7:0] tx_bytes[$];
    bit         tx_last[$];
    int         waits[$];

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (bus.txdv_out) begin
            run_len++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL txd_unexpected: got %02h, required no frame byte", bus.txd_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.txd_out !== e) begin
                    n_fail++;
                    $display("FAIL txd_byte: got %02h, required %02h", bus.txd_out, e);
                end
            end
        end else begin
            if (run_len != 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
            n_checks++;
            if (bus.txd_out !== 8'h00 || bus.txer_out !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_line: got txd=%02h txer=%b, required 00/0", bus.txd_out, bus.txer_out);
            end
        end
    end

    task automatic add_pkt(input int n, input logic [7:0] base, input logic [7:0] step, input bit good);
        logic [7:0] b;
        logic [7:0] fcs;
        logic [7:0] nn;
        nn  = (n < 8) ? 8'd8 : 8'(n);
        fcs = 8'h00;
        for (int i = 0; i < n; i++) begin
            tx_bytes.push_back(base + 8'(i) * step);
            tx_last.push_back(i == n - 1);
        end
        if (good) begin
            exp_q.push_back(8'h55);
            exp_q.push_back(8'h55);
            exp_q.push_back(8'h55);
            exp_q.push_back(8'h7F);
            exp_q.push_back(8'h12);
            exp_q.push_back(8'h34);
            exp_q.push_back(nn);
            for (int i = 0; i < int'(nn); i++) begin
                b = (i < n) ? base + 8'(i) * step : 8'h00;
                fcs ^= b;
                exp_q.push_back(b);
            end
            exp_q.push_back(fcs);
        end
    endtask

    task automatic drive_pkt();
        int w;
        waits.delete();
        for (int i = 0; i < tx_bytes.size(); i++) begin
            bus.tvalid_in = 1'b1;
            bus.tdata_in  = tx_bytes[i];
            bus.tlast_in  = tx_last[i];
            w = 0;
            while (!bus.tready_out) begin
                @(negedge clk);
                w++;
                if (w > 500) begin
                    $display("FAIL tready_timeout: waited %0d cycles, required <= 500", w);
                    $fatal(1, "stream stalled");
                end
            end
            waits.push_back(w);
            @(negedge clk);
        end
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        tx_bytes.delete();
        tx_last.delete();
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((exp_q.size() != 0 || bus.txdv_out) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c >= 3000) begin
            n_fail++;
            $display("FAIL frame_timeout: %0d bytes pending, required 0", exp_q.size());
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_run(input string name, input int len);
        int r;
        n_checks++;
        r = (runs.size() != 0) ? runs.pop_front() : -1;
        if (r !== len) begin
            n_fail++;
            $display("FAIL %s_txdv_len: got %0d, required %0d", name, r, len);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        bus.tdata_in  = 8'h00;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.tready_out !== 1'b0 || bus.txdv_out !== 1'b0 || bus.txd_out !== 8'h00 ||
            bus.stat_packet_sent_cnt !== 16'd0 || bus.stat_packet_drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b dv=%b d=%02h s=%0d dr=%0d, required 0/0/00/0/0",
                     bus.tready_out, bus.txdv_out, bus.txd_out,
                     bus.stat_packet_sent_cnt, bus.stat_packet_drop_cnt);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.tready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_tready: got %b, required 1", bus.tready_out);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        add_pkt(10, 8'h01, 8'h01, 1'b1);
        drive_pkt();
        n_checks++;
        if (bus.txdv_out !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got txdv=%b, required 0", bus.txdv_out);
        end
        @(negedge clk);
        n_checks++;
        if (bus.txdv_out !== 1'b1 || bus.txd_out !== 8'h55) begin
            n_fail++;
            $display("FAIL latency_first: got dv=%b d=%02h, required 1/55", bus.txdv_out, bus.txd_out);
        end
        wait_idle();
        check_run("basic", 18);
        n_checks++;
        if (bus.stat_packet_sent_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_sent: got %0d, required 1", bus.stat_packet_sent_cnt);
        end
    endtask

    task automatic test_pad();
        add_pkt(3, 8'hA1, 8'h11, 1'b1);
        drive_pkt();
        wait_idle();
        check_run("pad", 16);
        n_checks++;
        if (bus.stat_packet_sent_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL pad_sent: got %0d, required 2", bus.stat_packet_sent_cnt);
        end
    endtask

    task automatic test_oversize();
        add_pkt(101, 8'h10, 8'h03, 1'b0);
        drive_pkt();
        n_checks++;
        if (bus.stat_packet_drop_cnt !== 16'd1 || bus.tready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_at_limit: got drop=%0d rdy=%b, required 1/1",
                     bus.stat_packet_drop_cnt, bus.tready_out);
        end
        add_pkt(103, 8'h20, 8'h05, 1'b0);
        drive_pkt();
        n_checks++;
        if (bus.stat_packet_drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_state: got %0d, required 2", bus.stat_packet_drop_cnt);
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (runs.size() !== 0 || bus.stat_packet_sent_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_no_frame: got runs=%0d sent=%0d, required 0/2",
                     runs.size(), bus.stat_packet_sent_cnt);
        end
        add_pkt(100, 8'h07, 8'h0D, 1'b1);
        drive_pkt();
        wait_idle();
        check_run("max", 108);
        n_checks++;
        if (bus.stat_packet_sent_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL max_sent: got %0d, required 3", bus.stat_packet_sent_cnt);
        end
    endtask

    task automatic test_back_to_back();
        add_pkt(9, 8'hF0, 8'h07, 1'b1);
        add_pkt(4, 8'h3C, 8'h21, 1'b1);
        drive_pkt();
        n_checks++;
        if (waits.size() != 13 || waits[9] !== 29) begin
            n_fail++;
            $display("FAIL b2b_tready_low: got %0d, required 29",
                     (waits.size() > 9) ? waits[9] : -1);
        end
        wait_idle();
        check_run("b2b_first", 17);
        check_run("b2b_second", 16);
        n_checks++;
        if (bus.stat_packet_sent_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL b2b_sent: got %0d, required 5", bus.stat_packet_sent_cnt);
        end
    endtask

    task automatic test_reset_mid();
        add_pkt(10, 8'h81, 8'h02, 1'b1);
        drive_pkt();
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.txdv_out !== 1'b0 || bus.txd_out !== 8'h00 || bus.tready_out !== 1'b0 ||
            bus.stat_packet_sent_cnt !== 16'd0 || bus.stat_packet_drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got dv=%b d=%02h rdy=%b s=%0d dr=%0d, required 0/00/0/0/0",
                     bus.txdv_out, bus.txd_out, bus.tready_out,
                     bus.stat_packet_sent_cnt, bus.stat_packet_drop_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        check_run("truncated", 12);
        n_checks++;
        if (exp_q.size() !== 6) begin
            n_fail++;
            $display("FAIL truncated_rest: got %0d unsent, required 6", exp_q.size());
        end
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        add_pkt(5, 8'h5A, 8'h13, 1'b1);
        drive_pkt();
        wait_idle();
        check_run("after_reset", 16);
        n_checks++;
        if (bus.stat_packet_sent_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL after_reset_sent: got %0d, required 1", bus.stat_packet_sent_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_oversize();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_tx.md
SIMPLE_TX -- requirements
Module: simple_tx

Interface
REQ-001 Parameter G_MEM_SIZE, default 100, payload buffer depth in bytes (maximum payload length).
REQ-002 clk_in  input  1  single clock; all logic on rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 tdata_in  input  8  stream payload byte.
REQ-005 tvalid_in  input  1  stream byte valid.
REQ-006 tlast_in  input  1  last payload byte of packet.
REQ-007 tready_out  output  1  block accepts stream byte; a beat transfers on an edge with tvalid_in and tready_out both high.
REQ-008 txd_out  output  8  transmitted line byte.
REQ-009 txdv_out  output  1  line byte valid.
REQ-010 txer_out  output  1  line error flag; driven 0 at all times.
REQ-011 stat_packet_sent_cnt  output  16  count of frames transmitted.
REQ-012 stat_packet_drop_cnt  output  16  count of oversize packets discarded.

Function
REQ-013 Frame format, byte order on txd_out: SFD 0x55,0x55,0x55,0x7F; type 0x12,0x34; size byte = N; N payload bytes; FCS byte.
REQ-014 FCS SHALL be the XOR of all N transmitted payload bytes, including any padding bytes.
REQ-015 Packets with fewer than 8 bytes SHALL be padded with 0x00 to N=8; otherwise N = number of accepted bytes.
REQ-016 States: LOAD, DROP, SFD, TYPE, SIZE, PAYLOAD, FCS, GAP; reset state LOAD.
REQ-017 LOAD: tready_out=1; each beat is written to the buffer at an incrementing address from 0; a tlast beat moves to SFD.
REQ-018 LOAD with buffer holding G_MEM_SIZE bytes and a further non-tlast beat accepted: move to DROP, discard buffer contents.
REQ-019 A tlast beat arriving when exactly G_MEM_SIZE bytes are already stored SHALL also cause a drop (count, return to LOAD); a packet of exactly G_MEM_SIZE bytes is valid.
REQ-020 DROP: tready_out=1, beats discarded; on tlast beat increment stat_packet_drop_cnt, return to LOAD; no frame emitted.
REQ-021 Outputs txd_out/txdv_out SHALL be registered; if edge E accepts the tlast beat, the first SFD byte appears after edge E+1 with txdv_out=1.
REQ-022 The frame SHALL be contiguous: txdv_out high for exactly N+8 consecutive cycles.
REQ-023 tready_out SHALL be 0 in SFD, TYPE, SIZE, PAYLOAD, FCS, GAP.
REQ-024 GAP: txdv_out=0, txd_out=0x00 for 12 cycles, then LOAD with tready_out=1.
REQ-025 txd_out SHALL be 0x00 whenever txdv_out=0.
REQ-026 stat_packet_sent_cnt SHALL increment on the edge presenting the FCS byte; both counters wrap 0xFFFF->0x0000.
REQ-027 tvalid_in with tready_out=0 SHALL be ignored; no beat consumed.

Reset
REQ-028 rst_n_in low SHALL immediately force: state LOAD, tready_out=0 while low then 1 after release, txd_out=0x00, txdv_out=0, txer_out=0, both counters 0, write address 0.
REQ-029 Reset mid-frame SHALL truncate the frame at once; no FCS emitted, sent count not incremented.

Structure
REQ-030 Constants C_SFD (0x5555557F), C_PACKET_TYPE (0x1234), C_SIZE_MIN (0x08), gap length and state_t SHALL reside in shared package rx_tx_pkg, used by both transmit and receive paths.
REQ-031 Sequencing SHALL be a sub-module tx_fsm; buffer and stream capture stay in simple_tx.

Verification
REQ-032 Send 10 bytes 0x01..0x0A -> txd: 55 55 55 7F 12 34 0A 01..0A 0B, txdv high 18 cycles, sent_cnt=1.
REQ-033 Send 3 bytes A1 B2 C3 -> size 0x08, payload A1 B2 C3 00 00 00 00 00, FCS 0xD0, txdv 16 cycles.
REQ-034 Send 101 bytes (G_MEM_SIZE=100) -> no txdv, drop_cnt=1; then 100-byte packet -> transmitted, size 0x64.
REQ-035 Two back-to-back packets with tvalid held high -> tready_out low during frame plus 12 gap cycles, second frame intact, sent_cnt=2.
REQ-036 Assert rst_n_in during payload byte 5 -> txdv_out 0 immediately, counters 0; next packet transmitted correctly.
